// File: rtl/bus_activity_monitor_if.sv
// ============================================================================
// Module  : bus_activity_monitor_if
// Purpose : Groups the observed bus strobes, the custom-instruction slot and
//           the monitor outputs into one bundle.
// Ports   : beginTransaction, endTransaction, dataValid, busError,
//           readNotWrite (bus, observed only); start, ciN, valueA, valueB
//           (CI request); busIdle, busTimeout, done, result (monitor outputs).
//           master = bus/CPU side, slave = the monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_activity_monitor_if;
  logic        beginTransaction;
  logic        endTransaction;
  logic        dataValid;
  logic        busError;
  logic        readNotWrite;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        busIdle;
  logic        busTimeout;
  logic        done;
  logic [31:0] result;

  modport master (
    output beginTransaction, endTransaction, dataValid, busError, readNotWrite,
    output start, ciN, valueA, valueB,
    input  busIdle, busTimeout, done, result
  );

  modport slave (
    input  beginTransaction, endTransaction, dataValid, busError, readNotWrite,
    input  start, ciN, valueA, valueB,
    output busIdle, busTimeout, done, result
  );
endinterface

`default_nettype wire

// File: rtl/bus_activity_monitor.sv
// ============================================================================
// Module  : bus_activity_monitor
// Purpose : Passive bus observer. Tracks transaction boundaries (IDLE/ACTIVE)
//           to produce busIdle for the profiler, forces a timeout after
//           TIMEOUT_CYCLES ACTIVE cycles, and keeps four statistics
//           (reads, writes, data beats, errors) behind a CI slot.
// Ports   : clock, reset (async, active-high)
//           bus   - bus_activity_monitor_if.slave (strobes in, CI in,
//                   busIdle/busTimeout/done/result out)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_activity_monitor #(
  parameter logic [7:0] customId       = 8'h01,
  parameter int         TIMEOUT_CYCLES = 1023   // legal 2..65535
) (
  input  wire logic              clock,
  input  wire logic              reset,
  bus_activity_monitor_if.slave  bus
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t      state_q;
  logic [15:0] timer_q;
  logic        busTimeout_q;
  logic        done_q;
  logic [31:0] result_q;
  logic        enable_q, enable_d;
  logic [31:0] stats_q [4];
  logic [31:0] stats_d [4];

  logic isMe;
  logic accepted;
  logic inActive;
  logic errHit;
  logic timeoutHit;

  always_comb begin
    isMe       = bus.start && (bus.ciN == customId);
    accepted   = (state_q == IDLE) && bus.beginTransaction;
    inActive   = (state_q == ACTIVE);
    errHit     = inActive && bus.busError;
    // A timeout only fires when no strobe already closes the transaction.
    timeoutHit = inActive && !bus.busError && !bus.endTransaction &&
                 (timer_q == TIMER_LAST);
  end

  // Transaction FSM; busTimeout is registered alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= 16'd0;
      busTimeout_q <= 1'b0;
    end else begin
      busTimeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // begin+end together is a complete one-cycle transaction.
          if (bus.beginTransaction && !bus.endTransaction) begin
            state_q <= ACTIVE;
            timer_q <= 16'd0;
          end
        end
        ACTIVE: begin
          if (bus.busError || bus.endTransaction) begin
            state_q <= IDLE;
          end else if (timer_q == TIMER_LAST) begin
            state_q      <= IDLE;
            busTimeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Statistics next-state: increments gated by enable, clear overrides them.
  always_comb begin
    for (int i = 0; i < 4; i++) stats_d[i] = stats_q[i];
    if (enable_q) begin
      if (accepted && bus.readNotWrite)  stats_d[0] = stats_q[0] + 32'd1;
      if (accepted && !bus.readNotWrite) stats_d[1] = stats_q[1] + 32'd1;
      if (inActive && bus.dataValid)     stats_d[2] = stats_q[2] + 32'd1;
      if (errHit || timeoutHit)          stats_d[3] = stats_q[3] + 32'd1;
    end
    if (isMe && bus.valueB[2]) begin
      for (int i = 0; i < 4; i++) stats_d[i] = 32'd0;
    end
  end

  // Disable wins over enable when both are requested.
  always_comb begin
    enable_d = enable_q;
    if (isMe && bus.valueB[1])      enable_d = 1'b0;
    else if (isMe && bus.valueB[0]) enable_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) stats_q[i] <= 32'd0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      for (int i = 0; i < 4; i++) stats_q[i] <= stats_d[i];
      enable_q <= enable_d;
      done_q   <= isMe;
      // Result reflects the statistic before this cycle's clear/increment.
      result_q <= isMe ? stats_q[bus.valueA[1:0]] : 32'd0;
    end
  end

  assign bus.busIdle    = (state_q == IDLE);
  assign bus.busTimeout = busTimeout_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;

  // Operand bits with no function in this block.
  logic unused_bits;
  assign unused_bits = ^{bus.valueA[31:2], bus.valueB[31:3]};

endmodule

`default_nettype wire

// File: tb/tb_bus_activity_monitor.sv
// ============================================================================
// Module  : tb_bus_activity_monitor
// Purpose : Self-checking bench for bus_activity_monitor. A transaction-level
//           reference model predicts statistics, idle status and timeouts;
//           CI responses go through an expected-result queue popped by an
//           independent monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_activity_monitor;

  localparam int          TO  = 8;
  localparam logic [7:0]  CID = 8'h01;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bus_activity_monitor_if bif ();

  bus_activity_monitor #(
    .customId       (CID),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned m_s [4] = '{0, 0, 0, 0};
  bit          m_en     = 1'b0;
  bit          m_active = 1'b0;
  int          m_age    = 0;   // ACTIVE cycles spent in current transaction
  bit          m_to     = 1'b0;
  int unsigned expq [$];

  always @(posedge clock or posedge reset) begin : model
    bit          isme;
    bit          to;
    int unsigned nx [4];
    if (reset) begin
      m_s = '{0, 0, 0, 0};
      m_en = 0; m_active = 0; m_age = 0; m_to = 0;
      expq.delete();
    end else begin
      isme = bif.start && (bif.ciN == CID);
      if (isme) expq.push_back(m_s[bif.valueA[1:0]]);
      nx = m_s;
      to = 0;
      if (!m_active) begin
        if (bif.beginTransaction) begin
          if (bif.readNotWrite) nx[0] = nx[0] + 1;
          else                  nx[1] = nx[1] + 1;
          if (!bif.endTransaction) begin
            m_active = 1;
            m_age    = 0;
          end
        end
      end else begin
        if (bif.dataValid) nx[2] = nx[2] + 1;
        m_age = m_age + 1;
        if (bif.busError) begin
          nx[3] = nx[3] + 1;
          m_active = 0;
        end else if (bif.endTransaction) begin
          m_active = 0;
        end else if (m_age == TO) begin
          to = 1;
          nx[3] = nx[3] + 1;
          m_active = 0;
        end
      end
      if (m_en) m_s = nx;
      if (isme && bif.valueB[2]) m_s = '{0, 0, 0, 0};
      if (isme) begin
        if (bif.valueB[1])      m_en = 0;
        else if (bif.valueB[0]) m_en = 1;
      end
      m_to = to;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (!reset) begin
      chk("busIdle", {31'd0, bif.busIdle}, {31'd0, !m_active});
      chk("busTimeout", {31'd0, bif.busTimeout}, {31'd0, m_to});
      if (bif.done) begin
        if (expq.size() == 0) begin
          chk("done_unexpected", {31'd0, bif.done}, 32'd0);
        end else begin
          chk("ci_result", bif.result, expq.pop_front());
        end
      end else begin
        if (expq.size() != 0) begin
          chk("done_missing", {31'd0, bif.done}, 32'd1);
          void'(expq.pop_front());
        end
        chk("result_when_not_done", bif.result, 32'd0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bif.beginTransaction = 0; bif.endTransaction = 0; bif.dataValid = 0;
    bif.busError = 0; bif.readNotWrite = 0; bif.start = 0;
    bif.ciN = 8'h00; bif.valueA = 32'd0; bif.valueB = 32'd0;
  endtask

  // Issues one CI cycle and checks the response directly against expv.
  task automatic ci(input string name, input logic [1:0] sel, input logic [31:0] b,
                    input logic [31:0] expv);
    bif.start = 1; bif.ciN = CID; bif.valueA = {30'd0, sel}; bif.valueB = b;
    step();
    bif.start = 0; bif.valueA = 32'd0; bif.valueB = 32'd0;
    chk({name, "_done"}, {31'd0, bif.done}, 32'd1);
    chk(name, bif.result, expv);
  endtask

  task automatic txn(input bit rnw, input int beats);
    bif.beginTransaction = 1; bif.readNotWrite = rnw;
    step();
    bif.beginTransaction = 0;
    chk("busIdle_after_begin", {31'd0, bif.busIdle}, 32'd0);
    for (int i = 0; i < beats; i++) begin
      bif.dataValid = 1;
      step();
    end
    bif.dataValid = 0;
    bif.endTransaction = 1;
    step();
    bif.endTransaction = 0;
    chk("busIdle_after_end", {31'd0, bif.busIdle}, 32'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int act_cycles;
    int pulses;
    clear_inputs();
    reset = 1;
    repeat (3) step();
    reset = 0;
    repeat (5) step();
    chk("reset_busIdle", {31'd0, bif.busIdle}, 32'd1);
    chk("reset_done", {31'd0, bif.done}, 32'd0);
    chk("reset_result", bif.result, 32'd0);
    ci("reset_S0", 2'd0, 32'd0, 32'd0);
    ci("reset_S1", 2'd1, 32'd0, 32'd0);
    ci("reset_S2", 2'd2, 32'd0, 32'd0);
    ci("reset_S3", 2'd3, 32'd0, 32'd0);

    // Enable counting, one read (4 beats) and one write (2 beats).
    ci("enable", 2'd0, 32'h1, 32'd0);
    txn(1'b1, 4);
    txn(1'b0, 2);
    ci("S0_reads", 2'd0, 32'd0, 32'd1);
    ci("S1_writes", 2'd1, 32'd0, 32'd1);
    ci("S2_beats", 2'd2, 32'd0, 32'd6);

    // Begin with no end: forced timeout after TO ACTIVE cycles.
    bif.beginTransaction = 1; bif.readNotWrite = 1;
    step();
    bif.beginTransaction = 0;
    act_cycles = 0; pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bif.busIdle) act_cycles++;
      if (bif.busTimeout) pulses++;
      step();
    end
    chk("timeout_active_cycles", act_cycles, TO);
    chk("timeout_pulses", pulses, 32'd1);
    ci("S3_after_timeout", 2'd3, 32'd0, 32'd1);

    // Same-cycle begin+end in IDLE, then busError+end together in ACTIVE.
    bif.beginTransaction = 1; bif.endTransaction = 1; bif.readNotWrite = 1;
    step();
    bif.beginTransaction = 0; bif.endTransaction = 0;
    chk("begin_end_stays_idle", {31'd0, bif.busIdle}, 32'd1);
    bif.beginTransaction = 1; bif.readNotWrite = 0;
    step();
    bif.beginTransaction = 0;
    bif.busError = 1; bif.endTransaction = 1;
    step();
    bif.busError = 0; bif.endTransaction = 0;
    chk("err_end_idle", {31'd0, bif.busIdle}, 32'd1);
    ci("S3_err_once", 2'd3, 32'd0, 32'd2);
    ci("S0_begin_end", 2'd0, 32'd0, 32'd3);
    ci("S1_err_txn", 2'd1, 32'd0, 32'd2);

    // Clear while a data beat lands: pre-clear value returned, clear wins.
    bif.beginTransaction = 1; bif.readNotWrite = 1;
    step();
    bif.beginTransaction = 0;
    bif.dataValid = 1;
    ci("S2_preclear", 2'd2, 32'h4, 32'd6);
    bif.dataValid = 0;
    ci("S2_cleared", 2'd2, 32'd0, 32'd0);
    bif.endTransaction = 1;
    step();
    bif.endTransaction = 0;
    ci("S0_cleared", 2'd0, 32'd0, 32'd0);
    txn(1'b1, 1);

    // Foreign CI number: no response, no clear.
    bif.start = 1; bif.ciN = 8'h02; bif.valueB = 32'h4;
    step();
    bif.start = 0; bif.ciN = 8'h00; bif.valueB = 32'd0;
    chk("foreign_no_done", {31'd0, bif.done}, 32'd0);
    ci("S0_not_cleared", 2'd0, 32'd0, 32'd1);

    // valueB=3: disable wins; later read transaction is not counted.
    ci("disable", 2'd0, 32'h3, 32'd1);
    txn(1'b1, 2);
    ci("S0_disabled", 2'd0, 32'd0, 32'd1);
    ci("S2_disabled", 2'd2, 32'd0, 32'd1);

    // Reset in the middle of a transaction.
    bif.beginTransaction = 1; bif.readNotWrite = 0;
    step();
    bif.beginTransaction = 0;
    step();
    reset = 1;
    #1;
    chk("async_reset_idle", {31'd0, bif.busIdle}, 32'd1);
    step();
    reset = 0;
    step();
    ci("S1_after_reset", 2'd1, 32'd0, 32'd0);
    ci("reenable", 2'd0, 32'h1, 32'd0);

    // Randomized traffic; the scoreboard checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      bif.beginTransaction = ($urandom % 7) == 0;
      bif.endTransaction   = ($urandom % 6) == 0;
      bif.dataValid        = ($urandom % 3) == 0;
      bif.busError         = ($urandom % 25) == 0;
      bif.readNotWrite     = $urandom % 2;
      bif.start            = ($urandom % 5) == 0;
      bif.ciN              = (($urandom % 4) == 0) ? 8'h02 : CID;
      bif.valueA           = $urandom;
      bif.valueB           = {$urandom} & 32'hFFFF_FFFB;
      if (($urandom % 12) == 0) bif.valueB[2] = 1'b1;
      if (($urandom % 4) != 0) bif.valueB[1] = 1'b0;
      step();
    end
    clear_inputs();
    repeat (TO + 2) step();
    for (int s = 0; s < 4; s++) begin
      bif.start = 1; bif.ciN = CID; bif.valueA = s; bif.valueB = 32'd0;
      step();
    end
    clear_inputs();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
